// File: rtl/irq_sched.sv
// Interrupt scheduler: 32 IRQ lines plus a countdown timer, runtime/fixed masking,
// lowest-index-wins arbitration and a valid/ack/eoi handshake to the CPU.
module irq_sched #(
   parameter logic [31:0] MASKED_IRQ  = 32'h0000_0000,
   parameter logic [31:0] LATCHED_IRQ = 32'hffff_ffff,
   parameter bit          TIMER_EN    = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] irq_in,
   input  logic        mask_we,
   input  logic [31:0] mask_wdata,
   output logic [31:0] mask_q,
   input  logic        timer_we,
   input  logic [31:0] timer_wdata,
   output logic [31:0] timer_q,
   output logic [31:0] irq_pending,
   output logic        irq_valid,
   output logic [4:0]  irq_id,
   input  logic        irq_ack,
   input  logic        irq_eoi,
   output logic        in_service
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      OFFER   = 2'd1,
      SERVICE = 2'd2
   } state_t;

   state_t      state;
   logic [31:0] pend;
   logic [31:0] irq_in_d;
   logic [31:0] set_vec;
   logic [31:0] clr_vec;
   logic [31:0] eligible;
   logic [4:0]  winner;
   logic        timer_expire;

   generate
      if (TIMER_EN) begin : g_timer
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               timer_q <= '0;
            end else if (timer_we) begin
               timer_q <= timer_wdata;
            end else if (timer_q != 32'd0) begin
               timer_q <= timer_q - 32'd1;
            end
         end
         // A load in the same cycle overrides the 1->0 step, so no expiry is signalled.
         assign timer_expire = !timer_we && (timer_q == 32'd1);
      end else begin : g_no_timer
         logic unused_timer;
         assign unused_timer = ^{timer_we, timer_wdata};
         assign timer_q      = '0;
         assign timer_expire = 1'b0;
      end
   endgenerate

   assign set_vec = ((LATCHED_IRQ & irq_in & ~irq_in_d) |
                     (~LATCHED_IRQ & irq_in) |
                     {31'd0, timer_expire}) & ~MASKED_IRQ;

   assign clr_vec     = (state == OFFER && irq_ack) ? (32'd1 << irq_id) : 32'd0;
   assign eligible    = pend & ~mask_q;
   assign irq_pending = pend;

   always_comb begin
      winner = '0;
      for (int i = 31; i >= 0; i--) begin
         if (eligible[i]) winner = 5'(i);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend       <= '0;
         irq_in_d   <= '0;
         mask_q     <= 32'hffff_ffff;
         state      <= IDLE;
         irq_valid  <= 1'b0;
         irq_id     <= '0;
         in_service <= 1'b0;
      end else begin
         irq_in_d <= irq_in;
         // Set takes priority so an event arriving on the ack cycle is never lost.
         pend     <= (pend & ~clr_vec) | set_vec;
         if (mask_we) mask_q <= mask_wdata;

         case (state)
            IDLE: begin
               if (eligible != 32'd0) begin
                  state     <= OFFER;
                  irq_id    <= winner;
                  irq_valid <= 1'b1;
               end
            end
            OFFER: begin
               if (irq_ack) begin
                  state      <= SERVICE;
                  irq_valid  <= 1'b0;
                  in_service <= 1'b1;
               end
            end
            SERVICE: begin
               if (irq_eoi) begin
                  state      <= IDLE;
                  in_service <= 1'b0;
               end
            end
            default: begin
               state      <= IDLE;
               irq_valid  <= 1'b0;
               in_service <= 1'b0;
            end
         endcase
      end
   end

endmodule
